cvi_to_avst_video: RTL and testbench

- Clocked-video input: the receive-side counterpart of the clocked-video output (ITC) path.
- Takes a pixel stream with datavalid, h_sync and v_sync, frames it into Avalon-ST video packets (header beat, then pixels), and buffers them in a FIFO toward a backpressuring sink.
- Sits between the camera/format path and VIP/frame-buffer logic in the Qsys system.

---
 rtl/cvi_to_avst_video.sv | 167 ++++++++++++++++
 tb/tb_cvi_to_avst_video.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cvi_to_avst_video.sv
// Clocked-video input: frames a datavalid/v_sync pixel stream into Avalon-ST video
// packets (header beat then pixels) and buffers them in a show-ahead FIFO.
module cvi_to_avst_video #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned FIFO_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] vid_data,
  input  logic              vid_datavalid,
  input  logic              vid_h_sync,
  input  logic              vid_v_sync,
  output logic [DATA_W-1:0] source_data,
  output logic              source_valid,
  input  logic              source_ready,
  output logic              source_startofpacket,
  output logic              source_endofpacket,
  output logic              overflow,
  output logic              short_frame,
  output logic [15:0]       frame_count
);

  localparam int unsigned FRAME_PIX = WIDTH * HEIGHT;
  localparam int unsigned PIX_W     = $clog2(FRAME_PIX) + 1;
  localparam int unsigned ADDR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned ENTRY_W   = DATA_W + 2;
  localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(FRAME_PIX - 1);
  localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t                state;
  logic                  vs_prev;
  logic [PIX_W-1:0]      pix_cnt;
  logic [ENTRY_W-1:0]    mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [ADDR_W:0]       level;
  logic                  full;
  logic                  empty;
  logic                  push_req;
  logic                  push;
  logic                  pop;
  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    rd_entry;
  logic                  frame_start;
  logic                  frame_end;
  logic                  last_pix;
  logic                  unused_h_sync;

  assign unused_h_sync = vid_h_sync;

  assign full        = (level == FULL_LVL);
  assign empty       = (level == '0);
  assign frame_start = vs_prev & ~vid_v_sync;
  assign frame_end   = ~vs_prev & vid_v_sync;
  assign last_pix    = (pix_cnt == LAST_PIX);

  // Entry layout: {data, sop, eop}. Terminator is {0, sop=0, eop=1}.
  always_comb begin
    push_req   = 1'b0;
    push_entry = '0;
    unique case (state)
      IDLE: begin
        if (frame_start && enable) begin
          push_req   = 1'b1;
          push_entry = {{DATA_W{1'b0}}, 1'b1, 1'b0};
        end
      end
      ACTIVE: begin
        if (frame_end) begin
          push_req   = 1'b1;
          push_entry = {{DATA_W{1'b0}}, 1'b0, 1'b1};
        end else if (vid_datavalid) begin
          push_req   = 1'b1;
          push_entry = {vid_data, 1'b0, last_pix};
        end
      end
      FLUSH: begin
        push_req   = 1'b1;
        push_entry = {{DATA_W{1'b0}}, 1'b0, 1'b1};
      end
      default: ;
    endcase
  end

  // Full is judged on start-of-cycle occupancy, so a same-cycle pop never rescues a push.
  assign push = push_req & ~full;
  assign pop  = ~empty & source_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      vs_prev     <= 1'b0;
      pix_cnt     <= '0;
      overflow    <= 1'b0;
      short_frame <= 1'b0;
      frame_count <= '0;
    end else begin
      vs_prev <= vid_v_sync;
      unique case (state)
        IDLE: begin
          if (frame_start && enable) begin
            pix_cnt <= '0;
            if (full) overflow <= 1'b1;
            else      state    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (frame_end) begin
            short_frame <= 1'b1;
            if (full) begin
              overflow <= 1'b1;
              state    <= FLUSH;
            end else begin
              state <= IDLE;
            end
          end else if (vid_datavalid) begin
            if (full) begin
              overflow <= 1'b1;
              state    <= FLUSH;
            end else if (last_pix) begin
              frame_count <= frame_count + 16'd1;
              state       <= IDLE;
            end else begin
              pix_cnt <= pix_cnt + PIX_W'(1);
            end
          end
        end
        FLUSH: begin
          if (!full) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      unique case ({push, pop})
        2'b10:   level <= level + (ADDR_W + 1)'(1);
        2'b01:   level <= level - (ADDR_W + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign rd_entry             = mem[rd_ptr];
  assign source_valid         = ~empty;
  assign source_data          = empty ? '0 : rd_entry[ENTRY_W-1:2];
  assign source_startofpacket = ~empty & rd_entry[1];
  assign source_endofpacket   = ~empty & rd_entry[0];

endmodule

// File: tb/tb_cvi_to_avst_video.sv
// Directed bench for cvi_to_avst_video: scoreboard queues per instance, immediate assertions.
module tb_cvi_to_avst_video;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [23:0] vid_data;
  logic        vid_datavalid, vid_h_sync, vid_v_sync;
  logic        ready_m, ready_s;

  logic [23:0] m_data, s_data;
  logic        m_valid, m_sop, m_eop, m_ovf, m_short;
  logic        s_valid, s_sop, s_eop, s_ovf, s_short;
  logic [15:0] m_fc, s_fc;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_m = 1'b0;
  bit mon_s = 1'b0;
  logic [25:0] exp_m[$];
  logic [25:0] exp_s[$];

  always #5 clk = ~clk;

  cvi_to_avst_video #(.DATA_W(24), .WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .vid_data(vid_data),
    .vid_datavalid(vid_datavalid), .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync),
    .source_data(m_data), .source_valid(m_valid), .source_ready(ready_m),
    .source_startofpacket(m_sop), .source_endofpacket(m_eop),
    .overflow(m_ovf), .short_frame(m_short), .frame_count(m_fc));

  cvi_to_avst_video #(.DATA_W(24), .WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(4)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .vid_data(vid_data),
    .vid_datavalid(vid_datavalid), .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync),
    .source_data(s_data), .source_valid(s_valid), .source_ready(ready_s),
    .source_startofpacket(s_sop), .source_endofpacket(s_eop),
    .overflow(s_ovf), .short_frame(s_short), .frame_count(s_fc));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (mon_m && m_valid && ready_m) begin
      if (exp_m.size() == 0) check("extra_beat_m", 32'(m_valid), 32'd0);
      else check("beat_m", 32'({m_data, m_sop, m_eop}), 32'(exp_m.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (mon_s && s_valid && ready_s) begin
      if (exp_s.size() == 0) check("extra_beat_s", 32'(s_valid), 32'd0);
      else check("beat_s", 32'({s_data, s_sop, s_eop}), 32'(exp_s.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input bit to_s, input logic [23:0] d, input logic sop, input logic eop);
    if (to_s) exp_s.push_back({d, sop, eop});
    else      exp_m.push_back({d, sop, eop});
  endtask

  task automatic exp_full_frame(input bit to_s);
    exp_push(to_s, 24'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) exp_push(to_s, 24'(i), 1'b0, i == 8);
  endtask

  task automatic vs_pulse();
    vid_v_sync = 1'b1;
    tick();
    tick();
    vid_v_sync = 1'b0;
    tick();
  endtask

  task automatic pixels(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      vid_datavalid = 1'b1;
      vid_data      = 24'(first + i);
      tick();
    end
    vid_datavalid = 1'b0;
    vid_data      = '0;
  endtask

  task automatic wait_drain(input bit to_s);
    for (int i = 0; i < 200; i++) begin
      if ((to_s ? exp_s.size() : exp_m.size()) == 0) break;
      tick();
    end
    tick();
    if (to_s) check("drain_s", 32'(exp_s.size()), 32'd0);
    else      check("drain_m", 32'(exp_m.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; vid_data = '0; vid_datavalid = 1'b0;
    vid_h_sync = 1'b0; vid_v_sync = 1'b0; ready_m = 1'b1; ready_s = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_valid_m", 32'(m_valid), 0);
    check("rst_sop_m",   32'(m_sop), 0);
    check("rst_eop_m",   32'(m_eop), 0);
    check("rst_data_m",  32'(m_data), 0);
    check("rst_ovf_m",   32'(m_ovf), 0);
    check("rst_short_m", 32'(m_short), 0);
    check("rst_fc_m",    32'(m_fc), 0);
    check("rst_valid_s", 32'(s_valid), 0);

    // Overflow on the 4-deep instance
    mon_s = 1'b1; ready_s = 1'b0;
    exp_push(1, 24'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) exp_push(1, 24'(i), 1'b0, 1'b0);
    exp_push(1, 24'h0, 1'b0, 1'b1);
    vs_pulse();
    pixels(1, 8);
    repeat (3) tick();
    check("ovf_set_s",    32'(s_ovf), 1);
    check("ovf_valid_s",  32'(s_valid), 1);
    check("ovf_hdr_sop",  32'(s_sop), 1);
    check("ovf_hdr_data", 32'(s_data), 0);
    check("ovf_short_s",  32'(s_short), 0);
    ready_s = 1'b1;
    wait_drain(1);
    check("ovf_fc_s", 32'(s_fc), 0);
    exp_full_frame(1);
    vs_pulse();
    pixels(1, 8);
    wait_drain(1);
    check("after_ovf_fc_s", 32'(s_fc), 1);
    check("ovf_sticky_s",   32'(s_ovf), 1);
    check("idle_valid_s",   32'(s_valid), 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_fc_m",  32'(m_fc), 0);
    check("rst2_ovf_s", 32'(s_ovf), 0);
    check("rst2_fc_s",  32'(s_fc), 0);
    mon_s = 1'b0; mon_m = 1'b1;

    // Normal frame, ready high
    exp_full_frame(0);
    vs_pulse();
    pixels(1, 8);
    wait_drain(0);
    check("f1_fc",    32'(m_fc), 1);
    check("f1_ovf",   32'(m_ovf), 0);
    check("f1_short", 32'(m_short), 0);

    // Whole frame held under backpressure, then released as a burst
    ready_m = 1'b0;
    exp_full_frame(0);
    vs_pulse();
    pixels(1, 8);
    repeat (4) tick();
    check("hold_valid", 32'(m_valid), 1);
    check("hold_data",  32'(m_data), 0);
    check("hold_sop",   32'(m_sop), 1);
    check("hold_eop",   32'(m_eop), 0);
    tick();
    check("hold_sop_stable", 32'(m_sop), 1);
    ready_m = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("burst_valid", 32'(m_valid), 1);
    end
    @(negedge clk);
    check("burst_end_valid", 32'(m_valid), 0);
    check("burst_drained",   32'(exp_m.size()), 0);
    check("f2_fc",           32'(m_fc), 2);

    // Short frame; v_sync rise coincides with a dropped pixel
    exp_push(0, 24'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) exp_push(0, 24'(i), 1'b0, 1'b0);
    exp_push(0, 24'h0, 1'b0, 1'b1);
    vs_pulse();
    pixels(1, 5);
    enable = 1'b0;
    vid_v_sync = 1'b1; vid_datavalid = 1'b1; vid_data = 24'h66;
    tick();
    vid_datavalid = 1'b0; vid_data = '0;
    tick();
    vid_v_sync = 1'b0;
    tick();
    wait_drain(0);
    check("short_set", 32'(m_short), 1);
    check("short_fc",  32'(m_fc), 2);

    // Capture disabled at frame start, enable raised mid-frame
    vs_pulse();
    pixels(1, 8);
    repeat (3) tick();
    vs_pulse();
    pixels(1, 3);
    enable = 1'b1;
    pixels(4, 5);
    repeat (5) tick();
    check("dis_valid", 32'(m_valid), 0);
    check("dis_queue", 32'(exp_m.size()), 0);
    check("dis_fc",    32'(m_fc), 2);

    // Reset in the middle of a frame
    ready_m = 1'b0;
    vs_pulse();
    pixels(1, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 32'(m_valid), 0);
    check("mid_rst_fc",    32'(m_fc), 0);
    check("mid_rst_short", 32'(m_short), 0);
    pixels(4, 5);
    ready_m = 1'b1;
    repeat (4) tick();
    check("mid_rst_quiet", 32'(m_valid), 0);
    exp_full_frame(0);
    vs_pulse();
    pixels(1, 8);
    wait_drain(0);
    check("post_rst_fc",    32'(m_fc), 1);
    check("post_rst_ovf",   32'(m_ovf), 0);
    check("post_rst_short", 32'(m_short), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
